// File: rtl/axi_lite_uart_pkg.sv
// Shared constants for the AXI-Lite UART register front end: register offsets,
// IRQ bit indices, AXI response codes and CTRL field positions.
package axi_lite_uart_pkg;

  localparam logic [4:0] RegTxData   = 5'h00;
  localparam logic [4:0] RegRxData   = 5'h04;
  localparam logic [4:0] RegCtrl     = 5'h08;
  localparam logic [4:0] RegStatus   = 5'h0C;
  localparam logic [4:0] RegIrqEn    = 5'h10;
  localparam logic [4:0] RegIrqStat  = 5'h14;
  localparam logic [4:0] RegRxThresh = 5'h18;

  localparam int unsigned IrqRxThresh  = 0;
  localparam int unsigned IrqTxEmpty   = 1;
  localparam int unsigned IrqRxOvf     = 2;
  localparam int unsigned IrqRxErr     = 3;
  localparam int unsigned IrqRxTimeout = 4;
  localparam int unsigned NumIrq       = 5;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  localparam int unsigned CtrlBaudLsb   = 0;
  localparam int unsigned CtrlParityLsb = 4;
  localparam int unsigned CtrlTxEn      = 6;
  localparam int unsigned CtrlRxEn      = 7;
  localparam int unsigned CtrlTxFlush   = 8;
  localparam int unsigned CtrlRxFlush   = 9;
  localparam logic [7:0]  CtrlReset     = 8'hC0;

endpackage

// File: rtl/axi_lite_uart_ctrl_if.sv
// AXI4-Lite slave bus bundle for the UART register front end.
interface axi_lite_uart_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with level output and flush.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              a_reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   level_o
);
  localparam int unsigned Depth = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem_q [Depth];
  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [AWIDTH:0]   level_q;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AWIDTH + 1)'(Depth));
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (a_reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + {{AWIDTH{1'b0}}, do_push} - {{AWIDTH{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/axi_lite_uart_ctrl.sv
// AXI4-Lite register front end for the UART: TX/RX FIFOs, sticky errors, IRQs.
// Optional RX idle timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module axi_lite_uart_ctrl
  import axi_lite_uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned FIFO_AWIDTH      = 5,
  parameter int unsigned RX_TIMEOUT_TICKS = 32
) (
  input  logic                 clk,
  input  logic                 a_reset,
  axi_lite_uart_ctrl_if.slave  s_axi,
  output logic [3:0]           baud_sel,
  output logic [1:0]           parity,
  input  logic                 baud_tick,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_perr,
  input  logic                 rx_ferr,
  output logic                 uart_interrupt
);
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [4:0]            woff, roff;
  logic                  wr_hs, rd_hs;

  logic [7:0]            ctrl_q;
  logic [NumIrq-1:0]     irq_en_q;
  logic [7:0]            rx_thresh_q;
  logic                  ovf_q, err_q, irq_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q, wresp, rresp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [7:0]            tx_rdata;
  logic [9:0]            rx_rdata;
  logic                  tx_empty, tx_full, rx_empty, rx_full;
  logic [FIFO_AWIDTH:0]  tx_level, rx_level;
  logic                  tx_push_req, tx_pop, tx_drop, tx_flush;
  logic                  rx_push, rx_pop, rx_flush, rx_ovf_set, rx_err_set;
  logic [NumIrq-1:0]     irq_raw, irq_w1c;
  logic                  to_flag;

  assign waddr = s_axi.awaddr;
  assign raddr = s_axi.araddr;
  assign woff  = waddr[4:0];
  assign roff  = raddr[4:0];

  assign wr_hs = ~a_reset & s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
  assign rd_hs = ~a_reset & s_axi.arvalid & ~rvalid_q;

  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.arready = rd_hs;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign baud_sel       = ctrl_q[CtrlBaudLsb +: 4];
  assign parity         = ctrl_q[CtrlParityLsb +: 2];
  assign tx_data        = tx_rdata;
  assign tx_valid       = ctrl_q[CtrlTxEn] & ~tx_empty;
  assign uart_interrupt = irq_q;

  assign tx_push_req = wr_hs & (woff == RegTxData) & s_axi.wstrb[0];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign tx_flush    = wr_hs & (woff == RegCtrl) & s_axi.wstrb[1] & s_axi.wdata[CtrlTxFlush];
  assign rx_flush    = wr_hs & (woff == RegCtrl) & s_axi.wstrb[1] & s_axi.wdata[CtrlRxFlush];

  assign rx_push    = rx_valid & ctrl_q[CtrlRxEn];
  assign rx_pop     = rd_hs & (roff == RegRxData) & ~rx_empty;
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
  assign rx_err_set = rx_push & (rx_perr | rx_ferr);

  assign irq_w1c = (wr_hs && woff == RegIrqStat && s_axi.wstrb[0]) ?
                   s_axi.wdata[NumIrq-1:0] : '0;

  sync_fifo #(.WIDTH(8), .AWIDTH(FIFO_AWIDTH)) u_tx_fifo (
    .clk     (clk),
    .a_reset (a_reset),
    .flush_i (tx_flush),
    .push_i  (tx_push_req),
    .data_i  (s_axi.wdata[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_rdata),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .level_o (tx_level)
  );

  sync_fifo #(.WIDTH(10), .AWIDTH(FIFO_AWIDTH)) u_rx_fifo (
    .clk     (clk),
    .a_reset (a_reset),
    .flush_i (rx_flush),
    .push_i  (rx_push),
    .data_i  ({rx_ferr, rx_perr, rx_data}),
    .pop_i   (rx_pop),
    .data_o  (rx_rdata),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .level_o (rx_level)
  );

  always_comb begin
    irq_raw               = '0;
    irq_raw[IrqRxThresh]  = (rx_thresh_q != 8'd0) && (8'(rx_level) >= rx_thresh_q);
    irq_raw[IrqTxEmpty]   = tx_empty;
    irq_raw[IrqRxOvf]     = ovf_q;
    irq_raw[IrqRxErr]     = err_q;
    irq_raw[IrqRxTimeout] = to_flag;
  end

  always_comb begin
    wresp = RespOkay;
    case (woff)
      RegTxData:   if (tx_drop) wresp = RespSlvErr;
      RegRxData, RegCtrl, RegStatus, RegIrqEn, RegIrqStat, RegRxThresh: ;
      default:     wresp = RespDecErr;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RespOkay;
    case (roff)
      RegTxData:   ;
      RegRxData: begin
        if (rx_empty) rresp_d = RespSlvErr;
        else          rdata_d = {22'd0, rx_rdata};
      end
      RegCtrl:     rdata_d = {24'd0, ctrl_q};
      RegStatus:   rdata_d = {8'd0, 8'(rx_level), 8'(tx_level), 4'd0,
                              rx_full, rx_empty, tx_full, tx_empty};
      RegIrqEn:    rdata_d = {{(32 - NumIrq){1'b0}}, irq_en_q};
      RegIrqStat:  rdata_d = {{(32 - NumIrq){1'b0}}, irq_raw};
      RegRxThresh: rdata_d = {24'd0, rx_thresh_q};
      default:     rresp_d = RespDecErr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (a_reset) begin
      ctrl_q      <= CtrlReset;
      irq_en_q    <= '0;
      rx_thresh_q <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      rvalid_q    <= 1'b0;
      rresp_q     <= RespOkay;
      rdata_q     <= '0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wresp;
        if (s_axi.wstrb[0]) begin
          case (woff)
            RegCtrl:     ctrl_q      <= s_axi.wdata[7:0];
            RegIrqEn:    irq_en_q    <= s_axi.wdata[NumIrq-1:0];
            RegRxThresh: rx_thresh_q <= s_axi.wdata[7:0];
            default:     ;
          endcase
        end
      end else if (s_axi.bready) begin
        bvalid_q <= 1'b0;
      end

      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end

      // Set has priority over a same-cycle write-1-to-clear.
      ovf_q <= rx_ovf_set | (ovf_q & ~irq_w1c[IrqRxOvf]);
      err_q <= rx_err_set | (err_q & ~irq_w1c[IrqRxErr]);
      irq_q <= |(irq_raw & irq_en_q);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(RX_TIMEOUT_TICKS + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           to_q, to_clr, to_adv, to_set;

  assign to_clr  = rx_push | rx_pop | rx_flush;
  assign to_adv  = baud_tick & ~rx_empty & (to_cnt_q != ToW'(RX_TIMEOUT_TICKS));
  assign to_set  = ~to_clr & to_adv & (to_cnt_q == ToW'(RX_TIMEOUT_TICKS - 1));
  assign to_flag = to_q;

  always_ff @(posedge clk) begin
    if (a_reset) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (to_clr)      to_cnt_q <= '0;
      else if (to_adv) to_cnt_q <= to_cnt_q + 1'b1;
      to_q <= to_set | (to_q & ~irq_w1c[IrqRxTimeout]);
    end
  end
`else
  logic unused_timeout;
  assign to_flag        = 1'b0;
  assign unused_timeout = baud_tick | (RX_TIMEOUT_TICKS == 0);
`endif

  logic unused_bits;
  assign unused_bits = ^{waddr[ADDR_WIDTH-1:5], raddr[ADDR_WIDTH-1:5],
                         s_axi.wdata[31:10], s_axi.wstrb[3:2]};
endmodule

// File: tb/tb_axi_lite_uart_ctrl.sv
// Directed bench for axi_lite_uart_ctrl: register table plus FIFO/IRQ sequences.
module tb_axi_lite_uart_ctrl;
  localparam logic [15:0] ATx = 16'h00, ARx = 16'h04, ACtrl = 16'h08, AStat = 16'h0C;
  localparam logic [15:0] AIrqEn = 16'h10, AIrqSt = 16'h14, AThr = 16'h18;
  localparam logic [1:0]  OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic       clk = 1'b0;
  logic       a_reset = 1'b1;
  logic [3:0] baud_sel;
  logic [1:0] parity;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_perr = 1'b0, rx_ferr = 1'b0;
  logic       uart_interrupt;

  int n_vec = 0;
  int n_fail = 0;

  axi_lite_uart_ctrl_if #(.ADDR_WIDTH(16)) bus ();

  axi_lite_uart_ctrl #(.ADDR_WIDTH(16), .FIFO_AWIDTH(5), .RX_TIMEOUT_TICKS(32)) dut (
    .clk            (clk),
    .a_reset        (a_reset),
    .s_axi          (bus),
    .baud_sel       (baud_sel),
    .parity         (parity),
    .baud_tick      (baud_tick),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_perr        (rx_perr),
    .rx_ferr        (rx_ferr),
    .uart_interrupt (uart_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  function automatic vec_t mk(bit w, logic [15:0] a, logic [31:0] d, logic [31:0] e,
                              logic [1:0] r, string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.exp = e; v.exp_resp = r; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got no handshake, expected one within 50 cycles", name);
  endtask

  // Called and returns at posedge+1.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("aw_handshake");
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("b_response");
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("r_response");
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] e,
                        input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check({name, "_data"}, d, e);
    check({name, "_resp"}, {30'd0, r}, {30'd0, er});
  endtask

  task automatic wr_chk(input string name, input logic [15:0] a, input logic [31:0] d,
                        input logic [1:0] er);
    logic [1:0] r;
    axi_write(a, d, r);
    check({name, "_resp"}, {30'd0, r}, {30'd0, er});
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe, input logic fe);
    rx_data = d; rx_perr = pe; rx_ferr = fe; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baud_tick = 1'b1;
      @(posedge clk); #1;
      baud_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[20];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vecs[0]  = mk(0, ACtrl,  0,            32'h0C0,  OK,  "rst_ctrl");
    vecs[1]  = mk(0, AStat,  0,            32'h005,  OK,  "rst_status");
    vecs[2]  = mk(0, AIrqEn, 0,            32'h000,  OK,  "rst_irq_en");
    vecs[3]  = mk(0, AThr,   0,            32'h000,  OK,  "rst_thresh");
    vecs[4]  = mk(0, AIrqSt, 0,            32'h002,  OK,  "rst_irq_stat");
    vecs[5]  = mk(1, AIrqEn, 32'hFFFFFFFF, 0,        OK,  "wr_irq_en");
    vecs[6]  = mk(0, AIrqEn, 0,            32'h01F,  OK,  "rd_irq_en");
    vecs[7]  = mk(1, AIrqEn, 32'h0,        0,        OK,  "clr_irq_en");
    vecs[8]  = mk(1, AThr,   32'h1A5,      0,        OK,  "wr_thresh");
    vecs[9]  = mk(0, AThr,   0,            32'h0A5,  OK,  "rd_thresh");
    vecs[10] = mk(1, AThr,   32'h0,        0,        OK,  "clr_thresh");
    vecs[11] = mk(1, ACtrl,  32'h3F5,      0,        OK,  "wr_ctrl_flush");
    vecs[12] = mk(0, ACtrl,  0,            32'h0F5,  OK,  "rd_ctrl_selfclr");
    vecs[13] = mk(1, ACtrl,  32'h0C0,      0,        OK,  "restore_ctrl");
    vecs[14] = mk(0, 16'h1C, 0,            32'h0,    DEC, "rd_unmapped");
    vecs[15] = mk(1, 16'h1C, 32'h1234,     0,        DEC, "wr_unmapped");
    vecs[16] = mk(0, 16'h02, 0,            32'h0,    DEC, "rd_misaligned");
    vecs[17] = mk(0, ARx,    0,            32'h0,    SLV, "rd_rx_empty");
    vecs[18] = mk(1, AStat,  32'hFFFF,     0,        OK,  "wr_status_ro");
    vecs[19] = mk(0, AStat,  0,            32'h005,  OK,  "rd_status_again");

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    repeat (4) @(posedge clk);
    #1 a_reset = 1'b0;
    @(negedge clk);
    check("rst_bvalid", {31'd0, bus.bvalid}, 0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_irq", {31'd0, uart_interrupt}, 0);
    check("rst_baud_parity", {26'd0, parity, baud_sel}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) wr_chk(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].exp_resp);
      else               rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp, vecs[i].exp_resp);
    end

    // Baud/parity pins follow CTRL.
    wr_chk("ctrl_pins_wr", ACtrl, 32'h0F9, OK);
    check("ctrl_pins", {26'd0, parity, baud_sel}, {26'd0, 2'd3, 4'd9});
    wr_chk("ctrl_pins_restore", ACtrl, 32'h0C0, OK);

    // TX fall-through ordering and drain.
    wr_chk("tx_w41", ATx, 32'h41, OK);
    wr_chk("tx_w42", ATx, 32'h42, OK);
    @(negedge clk);
    check("tx_head0", {23'd0, tx_valid, tx_data}, 32'h141);
    tx_ready = 1'b1;
    @(negedge clk);
    check("tx_head1", {23'd0, tx_valid, tx_data}, 32'h142);
    @(negedge clk);
    check("tx_drained", {31'd0, tx_valid}, 0);
    tx_ready = 1'b0;
    @(posedge clk); #1;
    rd_chk("irq_tx_empty", AIrqSt, 32'h02, OK);

    // Fill TX to depth 32; the 33rd byte is refused.
    for (int i = 0; i < 33; i++) begin
      axi_write(ATx, i, r);
      check("tx_fill_resp", {30'd0, r}, (i < 32) ? 32'(OK) : 32'(SLV));
    end
    rd_chk("tx_full_status", AStat, 32'h0000_2006, OK);
    wr_chk("tx_flush", ACtrl, 32'h1C0, OK);
    rd_chk("ctrl_after_flush", ACtrl, 32'h0C0, OK);
    rd_chk("status_after_flush", AStat, 32'h005, OK);

    // RX byte with framing error; sticky error and W1C.
    rx_byte(8'h55, 1'b0, 1'b1);
    rd_chk("rx_ferr_byte", ARx, 32'h255, OK);
    rd_chk("irq_rx_err", AIrqSt, 32'h0A, OK);
    wr_chk("w1c_rx_err", AIrqSt, 32'h08, OK);
    rd_chk("irq_after_w1c", AIrqSt, 32'h02, OK);
    rd_chk("rx_empty_read", ARx, 32'h0, SLV);

    // Threshold interrupt rises one cycle after the 4th byte.
    wr_chk("thr4", AThr, 32'h4, OK);
    wr_chk("irq_en_thr", AIrqEn, 32'h1, OK);
    for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    check("irq_lag", {31'd0, uart_interrupt}, 0);
    @(negedge clk);
    check("irq_rise", {31'd0, uart_interrupt}, 1);
    @(posedge clk); #1;
    rd_chk("thr_pop", ARx, 32'h010, OK);
    check("irq_fall", {31'd0, uart_interrupt}, 0);
    wr_chk("irq_en_off", AIrqEn, 32'h0, OK);
    wr_chk("rx_flush", ACtrl, 32'h2C0, OK);
    rd_chk("status_rx_flushed", AStat, 32'h005, OK);

    // RX overflow: 33 pushes into a 32-deep FIFO.
    for (int i = 0; i < 33; i++) rx_byte(8'h80 + 8'(i), 1'b0, 1'b0);
    rd_chk("rx_full_status", AStat, 32'h0020_0009, OK);
    rd_chk("irq_ovf", AIrqSt, 32'h07, OK);
    wr_chk("w1c_ovf", AIrqSt, 32'h04, OK);
    rd_chk("irq_ovf_clr", AIrqSt, 32'h03, OK);

    // Same-cycle RXDATA pop and push on a full FIFO.
    bus.araddr = ARx; bus.arvalid = 1'b1;
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge clk);
    check("simul_arready", {31'd0, bus.arready}, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; rx_valid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    check("simul_rdata", {bus.rvalid, bus.rdata[30:0]}, 32'h8000_0080);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    rd_chk("simul_status", AStat, 32'h0020_0009, OK);
    rd_chk("simul_no_ovf", AIrqSt, 32'h03, OK);

`ifdef UART_RX_TIMEOUT_EN
    ticks(31);
    rd_chk("timeout_not_yet", AIrqSt, 32'h03, OK);
    ticks(1);
    rd_chk("timeout_set", AIrqSt, 32'h13, OK);
`else
    ticks(40);
    rd_chk("timeout_absent", AIrqSt, 32'h03, OK);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_uart_ctrl.md
# axi_lite_uart_ctrl

Parametrised AXI4-Lite register front end for the UART subsystem. It provides configurable-depth TX and RX FIFOs, per-byte RX error capture, sticky error flags, an RX level threshold and a maskable interrupt controller. It sits between the AXI-Lite interconnect and the existing baud generator and TX/RX serial engines, and drives their configuration, byte streams and baud selection.

## Interface
- ADDR_WIDTH, 16: AXI address width; offset decode uses bits [4:0].
- FIFO_AWIDTH, 5: FIFO depth = 2^FIFO_AWIDTH, legal range 2..7; levels are FIFO_AWIDTH+1 bits.
- RX_TIMEOUT_TICKS, 32: baud ticks of RX idle before timeout; used only under the macro.
- clk in 1: single clock.
- a_reset in 1: synchronous, active-high reset.
- s_axi_aw*/w*/b*/ar*/r* (awaddr, awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr, arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready): AXI4-Lite slave.
- baud_sel out 4: CTRL[3:0] to baud generator.
- parity out 2: CTRL[5:4]; 0 none, 1 even, 2 odd, 3 reserved (treated as none).
- baud_tick in 1: baud generator tick, used for timeout.
- tx_data out 8, tx_valid out 1, tx_ready in 1: byte stream to TX engine; transfer on valid&ready.
- rx_data in 8, rx_valid in 1, rx_perr in 1, rx_ferr in 1: one-cycle pulse per received byte with its error flags.
- uart_interrupt out 1: level interrupt.

## Operation
- Register map:
  - 0x00 TXDATA W: wstrb[0] pushes wdata[7:0].
  - 0x04 RXDATA R: pops the FIFO; rdata[7:0] byte, [8] perr, [9] ferr.
  - 0x08 CTRL RW: [3:0] baud, [5:4] parity, [6] tx_en, [7] rx_en, [8] tx_flush, [9] rx_flush. The flush bits self-clear and read 0.
  - 0x0C STATUS R: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_level, [23:16] rx_level.
  - 0x10 IRQ_EN RW [4:0].
  - 0x14 IRQ_STAT: read returns raw sources; write-1-clears the sticky bits.
  - 0x18 RX_THRESH RW [7:0].
- IRQ sources:
  - bit0 rx_level ≥ RX_THRESH with RX_THRESH ≠ 0 (live).
  - bit1 tx_empty (live).
  - bit2 rx_overflow (sticky).
  - bit3 rx_error, perr|ferr (sticky).
  - bit4 rx_timeout (sticky; macro only, reads 0 without it).
  - uart_interrupt = |(IRQ_STAT & IRQ_EN), registered.
- TXDATA write when the TX FIFO is full and no pop occurs that cycle: byte dropped, bresp SLVERR (2'b10).
- RXDATA read when the RX FIFO is empty: rdata 0, rresp SLVERR, no pop.
- Unmapped address: reads return 0 with DECERR (2'b11); writes are ignored with DECERR.
- TX side: tx_valid = tx_en & !tx_empty. tx_data is the FIFO head (first-word fall-through). Pop on tx_valid&tx_ready.
- RX side: a byte is accepted when rx_valid & rx_en. If the RX FIFO is full and not popped in the same cycle, the byte is dropped and rx_overflow is set. Any perr/ferr sets rx_error, even if the byte is dropped.
- Full-FIFO push with a same-cycle pop is accepted, and the level is unchanged.
- Flush empties the FIFO next cycle. Sticky flags are unaffected.
- Sticky set and W1C in the same cycle: set wins.

## Timing
- Write channel:
  - awready and wready pulse together for 1 cycle when awvalid & wvalid & !bvalid.
  - Register update and FIFO push happen in the same edge.
  - bvalid is asserted the next cycle and held until bready.
- Read channel:
  - arready pulses for 1 cycle when arvalid & !rvalid.
  - rdata and rresp are registered, and rvalid is asserted the next cycle and held until rready.
  - RX pop occurs on the arready cycle.
- Read and write transactions proceed independently and concurrently. A simultaneous RXDATA pop and rx_valid push are both honoured.
- STATUS reflects state at the ar handshake edge.
- uart_interrupt lags the source by 1 cycle.
- Reset values:
  - All ready/valid signals 0; resp 0; rdata 0; tx_valid 0; uart_interrupt 0.
  - CTRL = 0x0C0 (tx_en = rx_en = 1, 9600 baud, no parity); IRQ_EN 0; RX_THRESH 0; sticky bits 0.
  - Both FIFOs empty.
- Reset mid-transaction abandons it; no response is issued.

## Configuration
- UART_RX_TIMEOUT_EN defined:
  - A counter advances on each baud_tick while the RX FIFO is non-empty.
  - It clears on any RX push, RX pop or flush.
  - Reaching RX_TIMEOUT_TICKS sets IRQ bit4 once and holds the counter until cleared.
- Undefined: no counter logic is generated, and bit4 reads 0.

## Structure
- Package axi_lite_uart_pkg holds:
  - register offset constants
  - IRQ bit indices
  - AXI resp codes OKAY/SLVERR/DECERR
  - CTRL field positions
- Sub-module sync_fifo (WIDTH, AWIDTH): first-word fall-through, level output, flush input, push accepted on full with same-cycle pop.
- Instantiated twice: TX at width 8, RX at width 10.

## Test plan
- Reset, then read CTRL → 0x0C0 OKAY; read STATUS → tx_empty = rx_empty = 1, levels 0.
- Write 0x41, 0x42 to TXDATA with tx_ready=1 → tx_data 0x41 then 0x42, tx_valid drops; IRQ bit1 raw = 1.
- Hold tx_ready=0 and write 33 bytes (AWIDTH 5) → 32 OKAY, 33rd SLVERR, tx_level = 32.
- Inject rx_data 0x55 with rx_ferr=1 → RXDATA read = 0x255; IRQ_STAT bit3 = 1; W1C 0x08 → 0. A read on the empty FIFO → SLVERR, rdata 0.
- RX_THRESH=4, IRQ_EN=0x01, push 4 bytes → uart_interrupt rises 1 cycle after the 4th; read 1 → falls.
- Fill RX to 32 and push a 33rd → rx_overflow set, level 32. Push while reading RXDATA in the same cycle → level stays 32, no overflow flag. With UART_RX_TIMEOUT_EN, 32 idle ticks → bit4 set.
